// File: rtl/eth_stats_pkg.sv
// Shared definitions for the Ethernet statistics bank.
//   rd_sel_e  : read-port field select encodings
//   sat_add   : add two counter values of a given width, either clamping at
//               all-ones or wrapping modulo 2^width
package eth_stats_pkg;

  typedef enum logic [1:0] {
    SEL_FRAMES = 2'd0,
    SEL_BYTES  = 2'd1,
    SEL_BAD    = 2'd2,
    SEL_TIME   = 2'd3
  } rd_sel_e;

  // Operands are carried 64 bits wide (the largest counter width) and are
  // expected to already fit in 'width' bits. The sum is formed one bit wider
  // so an overflow out of a 64-bit counter is still visible for clamping.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          width,
                                          input bit          saturate);
    logic [64:0] sum;
    logic [64:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = (65'd1 << width) - 65'd1;
    if (saturate && (sum > limit)) begin
      return limit[63:0];
    end
    return sum[63:0] & limit[63:0];
  endfunction

endpackage

// File: rtl/eth_stats_channel.sv
// One channel of the statistics bank: live frame/byte/bad counters plus the
// shadow copy taken on a snapshot.
//   clk, rst        : core clock, synchronous active-high reset
//   count_en        : events are dropped while low
//   ev_valid/len/bad: per-frame event for this channel
//   snap_req        : copy live counters to shadow this edge
//   snap_clear      : with snap_req, restart live counters from this cycle's event
//   shadow_*        : captured counters for the read mux
module eth_stats_channel
  import eth_stats_pkg::*;
#(
  parameter int CNT_W    = 64,
  parameter int LEN_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             ev_valid,
  input  logic [LEN_W-1:0] ev_len,
  input  logic             ev_bad,
  input  logic             snap_req,
  input  logic             snap_clear,
  output logic [CNT_W-1:0] shadow_frames,
  output logic [CNT_W-1:0] shadow_bytes,
  output logic [CNT_W-1:0] shadow_bad
);

  localparam bit SAT = (SATURATE != 0);

  logic [CNT_W-1:0] frames_reg, bytes_reg, bad_reg;
  logic [CNT_W-1:0] frames_next, bytes_next, bad_next;
  logic [CNT_W-1:0] frames_base, bytes_base, bad_base;
  logic [CNT_W-1:0] shadow_frames_reg, shadow_bytes_reg, shadow_bad_reg;
  logic             hit;

  assign hit = ev_valid & count_en;

  always_comb begin
    // A clearing snapshot restarts from zero, so an event in the same cycle
    // becomes the first contribution of the new interval instead of being lost.
    if (snap_req && snap_clear) begin
      frames_base = '0;
      bytes_base  = '0;
      bad_base    = '0;
    end else begin
      frames_base = frames_reg;
      bytes_base  = bytes_reg;
      bad_base    = bad_reg;
    end

    frames_next = frames_base;
    bytes_next  = bytes_base;
    bad_next    = bad_base;
    if (hit) begin
      frames_next = CNT_W'(sat_add(64'(frames_base), 64'd1, CNT_W, SAT));
      bytes_next  = CNT_W'(sat_add(64'(bytes_base), 64'(ev_len), CNT_W, SAT));
      if (ev_bad) begin
        bad_next = CNT_W'(sat_add(64'(bad_base), 64'd1, CNT_W, SAT));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_reg        <= '0;
      bytes_reg         <= '0;
      bad_reg           <= '0;
      shadow_frames_reg <= '0;
      shadow_bytes_reg  <= '0;
      shadow_bad_reg    <= '0;
    end else begin
      frames_reg <= frames_next;
      bytes_reg  <= bytes_next;
      bad_reg    <= bad_next;
      // Shadow takes the pre-edge live value, so this cycle's event is excluded.
      if (snap_req) begin
        shadow_frames_reg <= frames_reg;
        shadow_bytes_reg  <= bytes_reg;
        shadow_bad_reg    <= bad_reg;
      end
    end
  end

  assign shadow_frames = shadow_frames_reg;
  assign shadow_bytes  = shadow_bytes_reg;
  assign shadow_bad    = shadow_bad_reg;

endmodule

// File: rtl/eth_stats_bank.sv
// Multi-channel Ethernet statistics bank with coherent snapshot and a
// registered host read port.
//   clk, rst              : core clock, synchronous active-high reset
//   current_time          : free-running time base, captured on snapshot
//   count_en              : global counting enable
//   ev_valid/ev_len/ev_bad: per-channel frame events (ev_len packed LEN_W per channel)
//   snap_req/snap_clear   : snapshot request, optional clear of live counters
//   snap_done             : pulse the cycle after shadow registers update
//   rd_en/rd_ch/rd_sel    : read request; rd_sel picks frames/bytes/bad/timestamp
//   rd_data/rd_valid/rd_err: read response one cycle later; rd_data holds
module eth_stats_bank
  import eth_stats_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 64,
  parameter  int LEN_W    = 16,
  parameter  int SATURATE = 1,
  localparam int RD_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             current_time,
  input  logic                    count_en,
  input  logic [NUM_CH-1:0]       ev_valid,
  input  logic [NUM_CH*LEN_W-1:0] ev_len,
  input  logic [NUM_CH-1:0]       ev_bad,
  input  logic                    snap_req,
  input  logic                    snap_clear,
  output logic                    snap_done,
  input  logic                    rd_en,
  input  logic [RD_W-1:0]         rd_ch,
  input  logic [1:0]              rd_sel,
  output logic [CNT_W-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    rd_err
);

  logic [CNT_W-1:0] sh_frames [NUM_CH];
  logic [CNT_W-1:0] sh_bytes  [NUM_CH];
  logic [CNT_W-1:0] sh_bad    [NUM_CH];

  logic [63:0]      snap_time_reg;
  logic             snap_done_reg;
  logic [CNT_W-1:0] rd_data_reg, rd_data_next;
  logic             rd_valid_reg;
  logic             rd_err_reg, rd_err_next;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    eth_stats_channel #(
      .CNT_W    (CNT_W),
      .LEN_W    (LEN_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .count_en      (count_en),
      .ev_valid      (ev_valid[gi]),
      .ev_len        (ev_len[gi*LEN_W +: LEN_W]),
      .ev_bad        (ev_bad[gi]),
      .snap_req      (snap_req),
      .snap_clear    (snap_clear),
      .shadow_frames (sh_frames[gi]),
      .shadow_bytes  (sh_bytes[gi]),
      .shadow_bad    (sh_bad[gi])
    );
  end

  // Select by comparison rather than indexing so an out-of-range rd_ch
  // never addresses past the shadow arrays; it simply matches nothing.
  always_comb begin
    rd_data_next = '0;
    rd_err_next  = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rd_ch) == c) begin
        rd_err_next = 1'b0;
        case (rd_sel_e'(rd_sel))
          SEL_FRAMES: rd_data_next = sh_frames[c];
          SEL_BYTES:  rd_data_next = sh_bytes[c];
          SEL_BAD:    rd_data_next = sh_bad[c];
          SEL_TIME:   rd_data_next = CNT_W'(snap_time_reg);
          default:    rd_data_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_time_reg <= '0;
      snap_done_reg <= 1'b0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      rd_err_reg    <= 1'b0;
    end else begin
      snap_done_reg <= snap_req;
      rd_valid_reg  <= rd_en;
      rd_err_reg    <= rd_en & rd_err_next;
      if (snap_req) begin
        snap_time_reg <= current_time;
      end
      // Shadow registers are read before this edge's snapshot lands, so a
      // read coinciding with a snapshot sees the previous capture.
      if (rd_en) begin
        rd_data_reg <= rd_data_next;
      end
    end
  end

  assign snap_done = snap_done_reg;
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_err    = rd_err_reg;

endmodule

// File: tb/tb_eth_stats_bank.sv
// Bench for eth_stats_bank: two instances (saturating and wrapping, 3 channels,
// 32-bit counters, 24-bit lengths) driven with identical stimulus and compared
// each cycle against an arithmetic reference model, plus literal checks.
module tb_eth_stats_bank;

  localparam int NCH = 3;
  localparam int CW  = 32;
  localparam int LW  = 24;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   current_time;
  logic          count_en;
  logic [NCH-1:0]    ev_valid;
  logic [NCH*LW-1:0] ev_len;
  logic [NCH-1:0]    ev_bad;
  logic          snap_req, snap_clear;
  logic          rd_en;
  logic [1:0]    rd_ch;
  logic [1:0]    rd_sel;

  logic          s_done, w_done;
  logic [CW-1:0] s_data, w_data;
  logic          s_valid, w_valid, s_err, w_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eth_stats_bank #(.NUM_CH(NCH), .CNT_W(CW), .LEN_W(LW), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .current_time(current_time), .count_en(count_en),
    .ev_valid(ev_valid), .ev_len(ev_len), .ev_bad(ev_bad),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_done(s_done),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(s_data), .rd_valid(s_valid), .rd_err(s_err));

  eth_stats_bank #(.NUM_CH(NCH), .CNT_W(CW), .LEN_W(LW), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .current_time(current_time), .count_en(count_en),
    .ev_valid(ev_valid), .ev_len(ev_len), .ev_bad(ev_bad),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_done(w_done),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(w_data), .rd_valid(w_valid), .rd_err(w_err));

  // ---------------- reference model ----------------
  // Index v: 0 = saturating instance, 1 = wrapping instance. k: 0 frames, 1 bytes, 2 bad.
  longint unsigned m_live [2][NCH][3];
  longint unsigned m_sh   [2][NCH][3];
  longint unsigned m_ts;
  longint unsigned e_data [2];
  logic            e_done, e_valid, e_err;
  bit              model_ready = 0;

  function automatic longint unsigned madd(longint unsigned a, longint unsigned b, int v);
    longint unsigned s;
    s = a + b;
    if (v == 0) return (s > MAXV) ? MAXV : s;
    return s % (MAXV + 1);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int v = 0; v < 2; v++) begin
        for (int c = 0; c < NCH; c++) begin
          for (int k = 0; k < 3; k++) begin
            m_live[v][c][k] = 0;
            m_sh[v][c][k]   = 0;
          end
        end
        e_data[v] = 0;
      end
      m_ts = 0; e_done = 0; e_valid = 0; e_err = 0;
      model_ready = 1;
    end else begin
      e_done  = snap_req;
      e_valid = rd_en;
      e_err   = rd_en && (rd_ch >= NCH);
      if (rd_en) begin
        for (int v = 0; v < 2; v++) begin
          if (rd_ch >= NCH)    e_data[v] = 0;
          else if (rd_sel == 3) e_data[v] = m_ts % (MAXV + 1);
          else                 e_data[v] = m_sh[v][rd_ch][rd_sel];
        end
      end
      if (snap_req) m_ts = current_time;
      for (int v = 0; v < 2; v++) begin
        for (int c = 0; c < NCH; c++) begin
          if (snap_req) begin
            for (int k = 0; k < 3; k++) m_sh[v][c][k] = m_live[v][c][k];
            if (snap_clear) for (int k = 0; k < 3; k++) m_live[v][c][k] = 0;
          end
          if (ev_valid[c] && count_en) begin
            m_live[v][c][0] = madd(m_live[v][c][0], 1, v);
            m_live[v][c][1] = madd(m_live[v][c][1], longint'(ev_len[c*LW +: LW]), v);
            m_live[v][c][2] = madd(m_live[v][c][2], longint'(ev_bad[c]), v);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (model_ready) begin
      chk("model sat snap_done",  64'(s_done),  64'(e_done));
      chk("model wrap snap_done", 64'(w_done),  64'(e_done));
      chk("model sat rd_valid",   64'(s_valid), 64'(e_valid));
      chk("model wrap rd_valid",  64'(w_valid), 64'(e_valid));
      chk("model sat rd_err",     64'(s_err),   64'(e_err));
      chk("model wrap rd_err",    64'(w_err),   64'(e_err));
      chk("model sat rd_data",    64'(s_data),  e_data[0]);
      chk("model wrap rd_data",   64'(w_data),  e_data[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    ev_valid     = '0;
    ev_bad       = '0;
    snap_req     = 1'b0;
    rd_en        = 1'b0;
    current_time = {$urandom, $urandom};
  endtask

  task automatic event1(input int c, input int len, input bit bad);
    ev_valid = '0; ev_valid[c] = 1'b1;
    ev_len   = '0; ev_len[c*LW +: LW] = LW'(len);
    ev_bad   = '0; ev_bad[c] = bad;
    step();
  endtask

  task automatic snap(input bit clr);
    snap_req = 1'b1; snap_clear = clr;
    step();
    chk("snap_done sat",  64'(s_done), 64'd1);
    chk("snap_done wrap", 64'(w_done), 64'd1);
  endtask

  task automatic rd_chk(input string nm, input int ch, input int sel,
                        input logic [31:0] exp_s, input logic [31:0] exp_w, input bit exp_err);
    rd_en = 1'b1; rd_ch = 2'(ch); rd_sel = 2'(sel);
    step();
    $display("read %s ch=%0d sel=%0d sat=%0h wrap=%0h err=%0b", nm, ch, sel, s_data, w_data, s_err);
    chk({nm, " valid"},     64'(s_valid & w_valid), 64'd1);
    chk({nm, " sat data"},  64'(s_data), 64'(exp_s));
    chk({nm, " wrap data"}, 64'(w_data), 64'(exp_w));
    chk({nm, " err"},       64'(s_err | w_err), 64'(exp_err));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; count_en = 1'b1; ev_valid = '0; ev_len = '0; ev_bad = '0;
    snap_req = 1'b0; snap_clear = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
    current_time = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset snap_done", 64'(s_done | w_done), 64'd0);

    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 4; s++) rd_chk("reset", c, s, 0, 0, 1'b0);
    rd_chk("oob", NCH, 0, 0, 0, 1'b1);

    // Three frames on ch0, one bad, then snapshot at time 0x1234.
    event1(0, 64, 1'b0);
    event1(0, 1500, 1'b1);
    event1(0, 60, 1'b0);
    current_time = 64'h1234;
    snap(1'b0);
    rd_chk("ch0 frames", 0, 0, 3, 3, 1'b0);
    rd_chk("ch0 bytes",  0, 1, 1624, 1624, 1'b0);
    rd_chk("ch0 bad",    0, 2, 1, 1, 1'b0);
    rd_chk("ch0 time",   0, 3, 32'h1234, 32'h1234, 1'b0);

    // Event coinciding with a clearing snapshot lands in the new interval.
    ev_valid = 3'b010; ev_len = '0; ev_len[LW +: LW] = 24'd100;
    snap(1'b1);
    rd_chk("ch1 excl frames", 1, 0, 0, 0, 1'b0);
    snap(1'b1);
    rd_chk("ch1 kept frames", 1, 0, 1, 1, 1'b0);
    rd_chk("ch1 kept bytes",  1, 1, 100, 100, 1'b0);
    rd_chk("ch0 cleared",     0, 0, 0, 0, 1'b0);

    // Disabled counting drops events.
    count_en = 1'b0;
    repeat (5) event1(0, 77, 1'b1);
    count_en = 1'b1;
    snap(1'b1);
    rd_chk("count_en frames", 0, 0, 0, 0, 1'b0);
    rd_chk("count_en bytes",  0, 1, 0, 0, 1'b0);

    // Drive ch2 bytes past 2^32-1: 257 * 0xFFFFFF = 0x1_00FF_FEFF.
    repeat (257) event1(2, 24'hFFFFFF, 1'b1);
    snap(1'b0);
    rd_chk("ch2 sat bytes",  2, 1, 32'hFFFF_FFFF, 32'h00FF_FEFF, 1'b0);
    rd_chk("ch2 sat frames", 2, 0, 257, 257, 1'b0);

    // Randomized traffic, snapshots and reads.
    for (int i = 0; i < 2000; i++) begin
      count_en   = ($urandom_range(0, 9) != 0);
      ev_valid   = NCH'($urandom);
      ev_bad     = NCH'($urandom);
      for (int c = 0; c < NCH; c++)
        ev_len[c*LW +: LW] = ($urandom_range(0, 7) == 0) ? LW'($urandom) : LW'($urandom_range(0, 1600));
      snap_req   = ($urandom_range(0, 9) == 0);
      snap_clear = $urandom_range(0, 1) != 0;
      rd_en      = $urandom_range(0, 1) != 0;
      rd_ch      = 2'($urandom_range(0, 3));
      rd_sel     = 2'($urandom);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a burst, with a read pending.
    for (int i = 0; i < 5; i++) begin
      ev_valid = NCH'($urandom); ev_bad = NCH'($urandom);
      step();
    end
    rst = 1'b1; ev_valid = '1; rd_en = 1'b1; rd_ch = 2'd0; rd_sel = 2'd1;
    step();
    rst = 1'b0;
    chk("rst discards read", 64'(s_valid | w_valid), 64'd0);
    snap(1'b0);
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 3; s++) rd_chk("post-rst", c, s, 0, 0, 1'b0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_stats_bank.md
Name: eth_stats_bank

Overview:
Parametrised multi-channel Ethernet statistics accumulator: the next generation of the per-port stats collector. It accepts NUM_CH per-frame event streams, already in the core clock domain, and keeps live frame, byte and bad-frame counters per channel. A single snapshot request copies all live counters plus a timestamp into shadow registers in one cycle, so all channels are captured coherently. Clear-on-snapshot and saturating counters are optional. A simple registered read port serves the host-side register block.

Parameters:
NUM_CH, 4, number of channels (1..16)
CNT_W, 64, width of every counter (32..64)
LEN_W, 16, width of the per-frame length field
SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap modulo 2^CNT_W

Ports:
clk  in  1  core clock; the only clock in the block
rst  in  1  synchronous, active-high reset
current_time  in  64  free-running time base
count_en  in  1  counting enable; events arriving while low are dropped
ev_valid  in  NUM_CH  one-cycle frame event per channel
ev_len  in  NUM_CH*LEN_W  frame length in bytes; channel c occupies [c*LEN_W +: LEN_W]
ev_bad  in  NUM_CH  frame had a CRC/length error
snap_req  in  1  one-cycle snapshot request
snap_clear  in  1  sampled with snap_req; 1 = zero live counters on snapshot
snap_done  out  1  one-cycle pulse when shadow registers are updated
rd_en  in  1  read strobe
rd_ch  in  clog2(NUM_CH) (min 1)  channel select
rd_sel  in  2  0 frames, 1 bytes, 2 bad frames, 3 snapshot timestamp
rd_data  out  CNT_W  read data; held until the next rd_en
rd_valid  out  1  one-cycle pulse, 1 cycle after rd_en
rd_err  out  1  with rd_valid: rd_ch >= NUM_CH

Behaviour:
- Reset (rst high at a clk edge): all live counters, shadow counters, shadow timestamp, rd_data, rd_valid, rd_err and snap_done go to 0. A snapshot or read in progress is discarded.
- Live update, per channel c, on each clk where ev_valid[c] & count_en:
  - frames += 1
  - bytes += zero-extended ev_len
  - bad += ev_bad[c]
- Width and overflow:
  - SATURATE=1: each sum is computed CNT_W+1 wide and clamped to all-ones, e.g. bytes = all-ones - 10 plus len 100 gives all-ones.
  - SATURATE=0: sums wrap modulo 2^CNT_W.
- Snapshot (snap_req high at edge N), in the same edge:
  - shadow[c] <= live[c] value before edge N, for every channel.
  - Shadow timestamp <= current_time sampled at edge N.
  - snap_done is high during cycle N+1. Latency is 1 cycle, and the snapshot is coherent across all channels.
- Snapshot together with events in the same cycle:
  - The event is excluded from the shadow copy.
  - If snap_clear=1, live <= event contribution only (e.g. frames=1), so no event is lost.
  - If snap_clear=0, live accumulates normally.
- count_en=0 does not block snapshots.
- Back-to-back snap_req is allowed every cycle; each one produces its own snap_done.
- Read port:
  - Reads always return shadow registers, never live counters.
  - rd_en at edge N: rd_data and rd_valid are driven during cycle N+1.
  - rd_sel=3 returns the timestamp; the upper bits are zero-padded if CNT_W>64, and the value is truncated to CNT_W if CNT_W<64.
  - Out-of-range rd_ch returns rd_data=0 and rd_err=1.
  - A read in the same cycle as a snapshot returns the old shadow value.
- No state machine. The block is a single pipeline stage: accumulate, shadow, read mux.

Decomposition:
- Package eth_stats_pkg holds:
  - the rd_sel encodings (SEL_FRAMES=0, SEL_BYTES=1, SEL_BAD=2, SEL_TIME=3);
  - a function sat_add(a, b, width, saturate).
- One sub-module, eth_stats_channel: the per-channel live and shadow counter triplet, instantiated NUM_CH times with a generate loop.
- The read mux and timestamp live in the top level.

Test Plan:
- Reset then read every channel and sel -> rd_data=0, rd_valid 1 cycle after rd_en, rd_err=0; rd_ch=NUM_CH -> rd_err=1, rd_data=0.
- Ch0: 3 events with len 64, 1500, 60, one bad; then snap_req -> frames=3, bytes=1624, bad=1, snap_done 1 cycle after request.
- current_time=0x1234 at the snap_req edge -> rd_sel=3 returns 0x1234.
- Event on ch1 with len 100 in the same cycle as snap_req with snap_clear=1 -> shadow excludes the event; second snapshot shows frames=1, bytes=100.
- SATURATE=1, CNT_W=32, bytes preset near 2^32-1 via events -> reads 0xFFFFFFFF. SATURATE=0 -> wrapped low value.
- count_en=0 with 5 events -> counters unchanged after snapshot.
- Assert rst in the middle of an event burst -> all reads return 0 on the next snapshot.
